pipe_fwd_sel: RTL and testbench



---
 rtl/pipe_pkg.sv | 23 ++
 rtl/fwd_cmp.sv | 30 +++
 rtl/pipe_fwd_sel.sv | 181 ++++++++++++++++++
 tb/tb_pipe_fwd_sel.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the operand-forwarding slice.
//   fwd_sel_e  : per-port operand source chosen in ID, applied in EX.
//   dst_mode_e : encoding of the ID destination-select field.
//   LINK_IDX   : link-register index (all ones, cast down to the index width).
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,  // register-file data latched in ID
    FWD_RF_BYP = 2'd1,  // WB result captured in ID (RF write not yet visible)
    FWD_MEM    = 2'd2,  // live MEM-stage result in EX
    FWD_WB     = 2'd3   // live WB-stage result in EX
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2,
    DST_NONE = 2'd3
  } dst_mode_e;

  localparam logic [31:0] LINK_IDX = '1;

endpackage

// File: rtl/fwd_cmp.sv
// Forward-select comparator for one read port.
//   src            : ID source register index
//   ex_/mem_/wb_rw : destination index held in each shadow stage
//   ex_/mem_/wb_wen: write enable held in each shadow stage
//   sel            : select code the operand will use once it reaches EX
// The youngest matching stage wins. A stage tag with wen=1 never carries
// index 0, so a zero source can never match and always yields FWD_RF.
module fwd_cmp
  import pipe_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] ex_rw,
  input  logic          ex_wen,
  input  logic [AW-1:0] mem_rw,
  input  logic          mem_wen,
  input  logic [AW-1:0] wb_rw,
  input  logic          wb_wen,
  output fwd_sel_e      sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_wen && ex_rw == src)        sel = FWD_MEM;
    else if (mem_wen && mem_rw == src) sel = FWD_WB;
    else if (wb_wen && wb_rw == src)   sel = FWD_RF_BYP;
  end

endmodule

// File: rtl/pipe_fwd_sel.sv
// Load-use stall detection and EX operand forwarding for a 5-stage pipe.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid, id_syscall       : ID holds an instruction / syscall source override
//   id_rs, id_rt, id_rd        : ID register fields
//   id_src_rt                  : port 0 reads rt instead of rs
//   id_dst_mode                : 0=rt, 1=rd, 2=link, 3=none
//   id_is_load                 : ID instruction is a load
//   rf_rdata                   : register-file read data, port p at [p*XLEN +: XLEN]
//   ex_/mem_/wb_result         : stage results
//   stall                      : freeze PC/IF/ID, inject EX bubble (combinational)
//   ex_opnd                    : forwarded EX operands, port p at [p*XLEN +: XLEN]
//   ex_rw, ex_wen              : EX destination index / write enable
//   stall_cnt                  : saturating count of load-use stall cycles
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NPORT  = 2,
  parameter int unsigned SYS_R0 = 2,
  parameter int unsigned SYS_R1 = 4,
  parameter int unsigned CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_syscall,
  input  logic [AW-1:0]         id_rs,
  input  logic [AW-1:0]         id_rt,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_src_rt,
  input  logic [1:0]            id_dst_mode,
  input  logic                  id_is_load,
  input  logic [NPORT*XLEN-1:0] rf_rdata,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  stall,
  output logic [NPORT*XLEN-1:0] ex_opnd,
  output logic [AW-1:0]         ex_rw,
  output logic                  ex_wen,
  output logic [CNTW-1:0]       stall_cnt
);

  logic [AW-1:0]   src    [NPORT];
  fwd_sel_e        sel_id [NPORT];
  fwd_sel_e        sel_q  [NPORT];
  logic [XLEN-1:0] base_q [NPORT];

  logic [AW-1:0] dst_rw;
  logic          dst_wen;
  logic          load_hit;

  // Shadow stages. is_load only matters in EX (a load in MEM or WB forwards
  // normally), so the older stages keep just {rw, wen}.
  logic [AW-1:0] ex_rw_q, mem_rw_q, wb_rw_q;
  logic          ex_wen_q, mem_wen_q, wb_wen_q;
  logic          ex_load_q;

  // ex_result is produced by the instruction currently in EX; consumers of it
  // see it one cycle later as mem_result, so it is never muxed here.
  logic unused_ex_result;
  assign unused_ex_result = ^ex_result;

  // Source indices per port.
  always_comb begin
    for (int unsigned p = 0; p < NPORT; p++) src[p] = id_rt;
    if (id_syscall) begin
      src[0] = AW'(SYS_R0);
      src[1] = AW'(SYS_R1);
    end else begin
      src[0] = id_src_rt ? id_rt : id_rs;
    end
  end

  // Destination index and write enable.
  always_comb begin
    dst_rw = '0;
    case (dst_mode_e'(id_dst_mode))
      DST_RT:   dst_rw = id_rt;
      DST_RD:   dst_rw = id_rd;
      DST_LINK: dst_rw = AW'(LINK_IDX);
      default:  dst_rw = '0;
    endcase
    dst_wen = id_valid && (dst_mode_e'(id_dst_mode) != DST_NONE) && (dst_rw != '0);
  end

  // Load-use hazard: the load in EX has no result until it reaches MEM.
  always_comb begin
    load_hit = 1'b0;
    for (int unsigned p = 0; p < NPORT; p++)
      if (src[p] != '0 && src[p] == ex_rw_q) load_hit = 1'b1;
  end

  assign stall = id_valid && ex_load_q && ex_wen_q && load_hit;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_cmp #(.AW(AW)) u_cmp (
      .src     (src[p]),
      .ex_rw   (ex_rw_q),
      .ex_wen  (ex_wen_q),
      .mem_rw  (mem_rw_q),
      .mem_wen (mem_wen_q),
      .wb_rw   (wb_rw_q),
      .wb_wen  (wb_wen_q),
      .sel     (sel_id[p])
    );
  end

  // Shadow stages: MEM and WB always advance; EX takes a bubble on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rw_q   <= '0;
      ex_wen_q  <= 1'b0;
      ex_load_q <= 1'b0;
      mem_rw_q  <= '0;
      mem_wen_q <= 1'b0;
      wb_rw_q   <= '0;
      wb_wen_q  <= 1'b0;
    end else begin
      mem_rw_q  <= ex_rw_q;
      mem_wen_q <= ex_wen_q;
      wb_rw_q   <= mem_rw_q;
      wb_wen_q  <= mem_wen_q;
      if (stall) begin
        ex_rw_q   <= '0;
        ex_wen_q  <= 1'b0;
        ex_load_q <= 1'b0;
      end else begin
        ex_rw_q   <= dst_rw;
        ex_wen_q  <= dst_wen;
        ex_load_q <= id_valid && id_is_load;
      end
    end
  end

  // Select codes and operand bases. RF_BYP latches wb_result now because the
  // WB write lands in the register file too late for rf_rdata this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        sel_q[p]  <= FWD_RF;
        base_q[p] <= '0;
      end
    end else if (stall) begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        sel_q[p]  <= FWD_RF;
        base_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        sel_q[p] <= sel_id[p];
        if (src[p] == '0)                base_q[p] <= '0;
        else if (sel_id[p] == FWD_RF_BYP) base_q[p] <= wb_result;
        else                             base_q[p] <= rf_rdata[p*XLEN +: XLEN];
      end
    end
  end

  // EX operand mux.
  always_comb begin
    ex_opnd = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      case (sel_q[p])
        FWD_MEM: ex_opnd[p*XLEN +: XLEN] = mem_result;
        FWD_WB:  ex_opnd[p*XLEN +: XLEN] = wb_result;
        default: ex_opnd[p*XLEN +: XLEN] = base_q[p];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign ex_rw  = ex_rw_q;
  assign ex_wen = ex_wen_q;

endmodule

// File: tb/tb_pipe_fwd_sel.sv
// Directed bench for pipe_fwd_sel. A second instance with a 6-bit stall
// counter shares all inputs so counter saturation is reachable quickly.
module tb_pipe_fwd_sel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_syscall, id_src_rt, id_is_load;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_dst_mode;
  logic [63:0] rf_rdata;
  logic [31:0] ex_result, mem_result, wb_result;

  logic        stall, ex_wen;
  logic [63:0] ex_opnd;
  logic [4:0]  ex_rw;
  logic [15:0] stall_cnt;

  logic        s_stall, s_ex_wen;
  logic [63:0] s_ex_opnd;
  logic [4:0]  s_ex_rw;
  logic [5:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] M_RT = 2'd0, M_RD = 2'd1, M_LINK = 2'd2, M_NONE = 2'd3;

  always #5 clk = ~clk;

  pipe_fwd_sel #(.XLEN(32), .AW(5), .NPORT(2), .SYS_R0(2), .SYS_R1(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_syscall(id_syscall),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_src_rt(id_src_rt),
    .id_dst_mode(id_dst_mode), .id_is_load(id_is_load), .rf_rdata(rf_rdata),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .stall(stall), .ex_opnd(ex_opnd), .ex_rw(ex_rw), .ex_wen(ex_wen),
    .stall_cnt(stall_cnt)
  );

  pipe_fwd_sel #(.XLEN(32), .AW(5), .NPORT(2), .SYS_R0(2), .SYS_R1(4), .CNTW(6)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_syscall(id_syscall),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_src_rt(id_src_rt),
    .id_dst_mode(id_dst_mode), .id_is_load(id_is_load), .rf_rdata(rf_rdata),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .stall(s_stall), .ex_opnd(s_ex_opnd), .ex_rw(s_ex_rw), .ex_wen(s_ex_wen),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [1:0] mode, input logic ld);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_dst_mode = mode;
    id_is_load  = ld;
    id_syscall  = 1'b0;
    id_src_rt   = 1'b0;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, M_NONE, 1'b0);
  endtask

  task automatic flush();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    nop();
    rf_rdata   = {32'h2222_2222, 32'h1111_1111};
    ex_result  = 32'h0;
    mem_result = 32'h0;
    wb_result  = 32'h0;

    // Reset state
    #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ex_rw", {27'd0, ex_rw}, 32'd0);
    check("rst_ex_wen", {31'd0, ex_wen}, 32'd0);
    check("rst_opnd0", ex_opnd[31:0], 32'd0);
    check("rst_opnd1", ex_opnd[63:32], 32'd0);
    check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ALU write r5 then read r5 as rs -> MEM forward
    set_id(1'b1, 5'd1, 5'd2, 5'd5, M_RD, 1'b0);
    tick();
    check("alu_ex_rw", {27'd0, ex_rw}, 32'd5);
    check("alu_ex_wen", {31'd0, ex_wen}, 32'd1);
    set_id(1'b1, 5'd5, 5'd6, 5'd0, M_NONE, 1'b0);
    #1;
    check("alu_nostall", {31'd0, stall}, 32'd0);
    tick();
    mem_result = 32'h0000_1234;
    #1;
    check("alu_fwd_mem", ex_opnd[31:0], 32'h0000_1234);
    check("alu_port1_rf", ex_opnd[63:32], 32'h2222_2222);
    check("alu_dst_none", {31'd0, ex_wen}, 32'd0);
    flush();

    // src_rt: both ports read r7 just written -> MEM forward on both
    set_id(1'b1, 5'd1, 5'd2, 5'd7, M_RD, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd7, 5'd0, M_NONE, 1'b0);
    id_src_rt = 1'b1;
    tick();
    mem_result = 32'h0000_7777;
    #1;
    check("srt_port0", ex_opnd[31:0], 32'h0000_7777);
    check("srt_port1", ex_opnd[63:32], 32'h0000_7777);
    flush();

    // Load r8 then use of r8 -> one stall cycle, then WB forward
    set_id(1'b1, 5'd1, 5'd8, 5'd0, M_RT, 1'b1);
    tick();
    set_id(1'b0, 5'd8, 5'd9, 5'd0, M_NONE, 1'b0);
    #1;
    check("lu_invalid_nostall", {31'd0, stall}, 32'd0);
    id_valid = 1'b1;
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_cnt0", {16'd0, stall_cnt}, 32'd0);
    tick();
    check("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
    check("lu_bubble_wen", {31'd0, ex_wen}, 32'd0);
    check("lu_bubble_opnd", ex_opnd[31:0], 32'd0);
    check("lu_stall_once", {31'd0, stall}, 32'd0);
    tick();
    wb_result = 32'hDEAD_BEEF;
    #1;
    check("lu_fwd_wb", ex_opnd[31:0], 32'hDEAD_BEEF);
    check("lu_cnt_hold", {16'd0, stall_cnt}, 32'd1);
    flush();

    // Writer of r3 three ahead -> RF_BYP captures WB result in ID
    set_id(1'b1, 5'd1, 5'd2, 5'd3, M_RD, 1'b0);
    tick();
    nop();
    tick();
    tick();
    set_id(1'b1, 5'd3, 5'd6, 5'd0, M_NONE, 1'b0);
    wb_result = 32'hCAFE_0001;
    tick();
    wb_result = 32'h5555_5555;
    #1;
    check("byp_captured", ex_opnd[31:0], 32'hCAFE_0001);
    flush();

    // Syscall with r2 in MEM and r4 in EX
    set_id(1'b1, 5'd1, 5'd1, 5'd2, M_RD, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd1, 5'd4, M_RD, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd7, 5'd0, M_NONE, 1'b0);
    id_syscall = 1'b1;
    tick();
    mem_result = 32'h4444_0004;
    wb_result  = 32'h2222_0002;
    #1;
    check("sys_port0_r2", ex_opnd[31:0], 32'h2222_0002);
    check("sys_port1_r4", ex_opnd[63:32], 32'h4444_0004);

    // Write to r0 is dropped; reads of r0 give 0
    set_id(1'b1, 5'd1, 5'd1, 5'd0, M_RD, 1'b0);
    tick();
    check("r0_wen", {31'd0, ex_wen}, 32'd0);
    set_id(1'b1, 5'd0, 5'd0, 5'd0, M_NONE, 1'b0);
    tick();
    check("r0_port0", ex_opnd[31:0], 32'd0);
    check("r0_port1", ex_opnd[63:32], 32'd0);
    flush();

    // jal then read r31
    set_id(1'b1, 5'd0, 5'd0, 5'd0, M_LINK, 1'b0);
    tick();
    check("jal_ex_rw", {27'd0, ex_rw}, 32'd31);
    check("jal_ex_wen", {31'd0, ex_wen}, 32'd1);
    set_id(1'b1, 5'd31, 5'd6, 5'd0, M_NONE, 1'b0);
    tick();
    mem_result = 32'h0040_0008;
    #1;
    check("jal_fwd_link", ex_opnd[31:0], 32'h0040_0008);
    flush();

    // r6 written three times in a row -> youngest (MEM) wins; also load in MEM
    set_id(1'b1, 5'd1, 5'd6, 5'd0, M_RT, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 5'd6, M_RD, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 5'd6, M_RD, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 5'd6, 5'd0, M_NONE, 1'b0);
    tick();
    mem_result = 32'hAAAA_0003;
    wb_result  = 32'hBBBB_0002;
    #1;
    check("prio_youngest", ex_opnd[31:0], 32'hAAAA_0003);
    set_id(1'b1, 5'd1, 5'd6, 5'd0, M_RT, 1'b1);
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd6, 5'd9, 5'd0, M_NONE, 1'b0);
    #1;
    check("ld_in_mem_nostall", {31'd0, stall}, 32'd0);
    tick();
    wb_result = 32'h0BAD_F00D;
    #1;
    check("ld_in_mem_fwd", ex_opnd[31:0], 32'h0BAD_F00D);
    flush();

    // 69 load-use stalls: small counter saturates at 63, main counts 1+69
    set_id(1'b1, 5'd8, 5'd8, 5'd0, M_RT, 1'b1);
    repeat (2 * 69) tick();
    nop();
    #1;
    check("sat_small", {26'd0, s_stall_cnt}, 32'd63);
    check("sat_main", {16'd0, stall_cnt}, 32'd70);
    flush();

    // Reset pulsed during a stall
    set_id(1'b1, 5'd1, 5'd8, 5'd0, M_RT, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd9, 5'd0, M_NONE, 1'b0);
    #1;
    check("mid_stall", {31'd0, stall}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_ex_rw", {27'd0, ex_rw}, 32'd0);
    check("mid_rst_ex_wen", {31'd0, ex_wen}, 32'd0);
    check("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("mid_rst_opnd", ex_opnd[31:0], 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_nostall", {31'd0, stall}, 32'd0);
    tick();
    check("post_rst_cnt", {16'd0, stall_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
